// File: rtl/lsu_mw_pipe.sv
// M and W pipeline stages of the P6 core: drives the external data bus from M, aligns and
// extends load data in W, and exports the GRF write-back trace plus forwarding/hazard info.
module lsu_mw_pipe #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [ADDR_W-1:0] e_pc,
  input  logic [OP_W-1:0]   e_op,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [31:0]       e_wdata,
  input  logic [31:0]       e_alu_res,
  input  logic [4:0]        e_rd,
  input  logic              e_reg_we,
  output logic [ADDR_W-1:0] m_data_addr,
  output logic [31:0]       m_data_wdata,
  output logic [3:0]        m_data_byteen,
  input  logic [31:0]       m_data_rdata,
  output logic [ADDR_W-1:0] m_inst_addr,
  output logic              m_misalign,
  output logic              m_fwd_we,
  output logic [4:0]        m_fwd_rd,
  output logic [31:0]       m_fwd_data,
  output logic              m_load_pending,
  output logic              w_grf_we,
  output logic [4:0]        w_grf_addr,
  output logic [31:0]       w_grf_wdata,
  output logic [ADDR_W-1:0] w_inst_addr
);

  localparam logic [OP_W-1:0] OpLw  = OP_W'(1);
  localparam logic [OP_W-1:0] OpLh  = OP_W'(2);
  localparam logic [OP_W-1:0] OpLhu = OP_W'(3);
  localparam logic [OP_W-1:0] OpLb  = OP_W'(4);
  localparam logic [OP_W-1:0] OpLbu = OP_W'(5);
  localparam logic [OP_W-1:0] OpSw  = OP_W'(6);
  localparam logic [OP_W-1:0] OpSh  = OP_W'(7);
  localparam logic [OP_W-1:0] OpSb  = OP_W'(8);

  // M stage registers
  logic              m_valid_q;
  logic [ADDR_W-1:0] m_pc_q;
  logic [OP_W-1:0]   m_op_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [31:0]       m_alu_q;
  logic [4:0]        m_rd_q;
  logic              m_reg_we_q;

  // W stage registers
  logic              w_valid_q;
  logic [ADDR_W-1:0] w_pc_q;
  logic [OP_W-1:0]   w_op_q;
  logic [1:0]        w_off_q;
  logic [31:0]       w_rdata_q;
  logic [31:0]       w_alu_q;
  logic [4:0]        w_rd_q;
  logic              w_reg_we_q;
  logic              w_misalign_q;

  logic              m_is_load;
  logic              m_mis;
  logic              w_is_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q    <= 1'b0;
      m_pc_q       <= '0;
      m_op_q       <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_alu_q      <= '0;
      m_rd_q       <= '0;
      m_reg_we_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      w_pc_q       <= '0;
      w_op_q       <= '0;
      w_off_q      <= '0;
      w_rdata_q    <= '0;
      w_alu_q      <= '0;
      w_rd_q       <= '0;
      w_reg_we_q   <= 1'b0;
      w_misalign_q <= 1'b0;
    end else begin
      m_valid_q    <= e_valid;
      m_pc_q       <= e_pc;
      m_op_q       <= e_op;
      m_addr_q     <= e_addr;
      m_wdata_q    <= e_wdata;
      m_alu_q      <= e_alu_res;
      m_rd_q       <= e_rd;
      m_reg_we_q   <= e_reg_we;
      w_valid_q    <= m_valid_q;
      w_pc_q       <= m_pc_q;
      w_op_q       <= m_op_q;
      w_off_q      <= m_addr_q[1:0];
      w_rdata_q    <= m_data_rdata;
      w_alu_q      <= m_alu_q;
      w_rd_q       <= m_rd_q;
      w_reg_we_q   <= m_reg_we_q;
      w_misalign_q <= m_mis;
    end
  end

  // M stage: bus drive, misalignment and forwarding
  always_comb begin
    logic [3:0] byteen_raw;
    m_is_load    = 1'b0;
    m_mis        = 1'b0;
    byteen_raw   = 4'b0000;
    m_data_wdata = '0;
    unique case (m_op_q)
      OpLw:  begin m_is_load = 1'b1; m_mis = |m_addr_q[1:0]; end
      OpLh:  begin m_is_load = 1'b1; m_mis = m_addr_q[0];    end
      OpLhu: begin m_is_load = 1'b1; m_mis = m_addr_q[0];    end
      OpLb:  m_is_load = 1'b1;
      OpLbu: m_is_load = 1'b1;
      OpSw: begin
        m_mis        = |m_addr_q[1:0];
        byteen_raw   = 4'b1111;
        m_data_wdata = m_wdata_q;
      end
      OpSh: begin
        m_mis        = m_addr_q[0];
        byteen_raw   = m_addr_q[1] ? 4'b1100 : 4'b0011;
        m_data_wdata = {m_wdata_q[15:0], m_wdata_q[15:0]};
      end
      OpSb: begin
        byteen_raw   = 4'b0001 << m_addr_q[1:0];
        m_data_wdata = {4{m_wdata_q[7:0]}};
      end
      default: ;
    endcase

    m_data_addr    = m_addr_q;
    m_inst_addr    = m_pc_q;
    m_fwd_rd       = m_rd_q;
    m_fwd_data     = m_alu_q;
    m_data_byteen  = (m_valid_q && !m_mis && !reset) ? byteen_raw : 4'b0000;
    m_misalign     = m_valid_q & m_mis & ~reset;
    m_fwd_we       = m_valid_q & m_reg_we_q & ~m_is_load & (m_rd_q != 5'd0) & ~reset;
    m_load_pending = m_valid_q & m_is_load & m_reg_we_q & (m_rd_q != 5'd0) & ~reset;
  end

  // W stage: load alignment/extension and GRF write-back
  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_sel;
    half     = w_off_q[1] ? w_rdata_q[31:16] : w_rdata_q[15:0];
    unique case (w_off_q)
      2'd0:    byte_sel = w_rdata_q[7:0];
      2'd1:    byte_sel = w_rdata_q[15:8];
      2'd2:    byte_sel = w_rdata_q[23:16];
      default: byte_sel = w_rdata_q[31:24];
    endcase

    w_is_load   = 1'b1;
    w_grf_wdata = w_alu_q;
    unique case (w_op_q)
      OpLw:    w_grf_wdata = w_rdata_q;
      OpLh:    w_grf_wdata = {{16{half[15]}}, half};
      OpLhu:   w_grf_wdata = {16'h0000, half};
      OpLb:    w_grf_wdata = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   w_grf_wdata = {24'h000000, byte_sel};
      default: w_is_load   = 1'b0;
    endcase

    w_grf_we    = w_valid_q & w_reg_we_q & ~w_misalign_q & (w_rd_q != 5'd0) & ~reset;
    w_grf_addr  = w_rd_q;
    w_inst_addr = w_pc_q;
  end

  logic unused_ok;
  assign unused_ok = w_is_load;

endmodule

// File: tb/tb_lsu_mw_pipe.sv
// Directed bench for lsu_mw_pipe with a small combinational-read / byte-write memory model.
module tb_lsu_mw_pipe;

  localparam logic [3:0] OpNone = 4'd0;
  localparam logic [3:0] OpLw   = 4'd1;
  localparam logic [3:0] OpLh   = 4'd2;
  localparam logic [3:0] OpLhu  = 4'd3;
  localparam logic [3:0] OpLb   = 4'd4;
  localparam logic [3:0] OpLbu  = 4'd5;
  localparam logic [3:0] OpSw   = 4'd6;
  localparam logic [3:0] OpSh   = 4'd7;
  localparam logic [3:0] OpSb   = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [31:0] e_pc;
  logic [3:0]  e_op;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_alu_res;
  logic [4:0]  e_rd;
  logic        e_reg_we;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic [31:0] m_inst_addr;
  logic        m_misalign;
  logic        m_fwd_we;
  logic [4:0]  m_fwd_rd;
  logic [31:0] m_fwd_data;
  logic        m_load_pending;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata;
  logic [31:0] w_inst_addr;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  lsu_mw_pipe #(.ADDR_W(32), .OP_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .e_valid        (e_valid),
    .e_pc           (e_pc),
    .e_op           (e_op),
    .e_addr         (e_addr),
    .e_wdata        (e_wdata),
    .e_alu_res      (e_alu_res),
    .e_rd           (e_rd),
    .e_reg_we       (e_reg_we),
    .m_data_addr    (m_data_addr),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_data_rdata   (m_data_rdata),
    .m_inst_addr    (m_inst_addr),
    .m_misalign     (m_misalign),
    .m_fwd_we       (m_fwd_we),
    .m_fwd_rd       (m_fwd_rd),
    .m_fwd_data     (m_fwd_data),
    .m_load_pending (m_load_pending),
    .w_grf_we       (w_grf_we),
    .w_grf_addr     (w_grf_addr),
    .w_grf_wdata    (w_grf_wdata),
    .w_inst_addr    (w_inst_addr)
  );

  assign m_data_rdata = mem[m_data_addr[7:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (m_data_byteen[b]) mem[m_data_addr[7:2]][b*8 +: 8] <= m_data_wdata[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [31:0] pc, input logic [3:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu,
                       input logic [4:0] rd, input logic we);
    e_valid = v; e_pc = pc; e_op = op; e_addr = addr;
    e_wdata = wd; e_alu_res = alu; e_rd = rd; e_reg_we = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " byteen"}, {28'h0, m_data_byteen}, 32'h0);
    check({tag, " grf_we"}, {31'h0, w_grf_we}, 32'h0);
    check({tag, " fwd_we"}, {31'h0, m_fwd_we}, 32'h0);
    check({tag, " load_pending"}, {31'h0, m_load_pending}, 32'h0);
    check({tag, " misalign"}, {31'h0, m_misalign}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1;
    issue(1'b1, 32'h100, OpSw, 32'h10, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0);
    #1;
    check_quiet("pre-edge");
    for (int c = 0; c < 3; c++) begin
      tick();
      check_quiet("in reset");
    end
    check("rst data_addr", m_data_addr, 32'h0);
    check("rst data_wdata", m_data_wdata, 32'h0);
    check("rst inst_addr", m_inst_addr, 32'h0);
    check("rst w_inst_addr", w_inst_addr, 32'h0);
    check("rst w_grf_wdata", w_grf_wdata, 32'h0);
    check("rst mem4 untouched", mem[4], 32'h0);

    reset = 1'b0;
    issue(1'b1, 32'h3000, OpSw, 32'h10, 32'h12345678, 32'h0, 5'd0, 1'b0);
    tick();
    check("sw byteen", {28'h0, m_data_byteen}, 32'hF);
    check("sw addr", m_data_addr, 32'h10);
    check("sw inst_addr", m_inst_addr, 32'h3000);
    check("sw wdata", m_data_wdata, 32'h12345678);

    issue(1'b1, 32'h3004, OpSb, 32'h13, 32'h000000AB, 32'h0, 5'd0, 1'b0);
    tick();
    check("sw landed", mem[4], 32'h12345678);
    check("sb byteen", {28'h0, m_data_byteen}, 32'h8);
    check("sb wdata", m_data_wdata, 32'hABABABAB);
    check("sw in W no grf", {31'h0, w_grf_we}, 32'h0);

    issue(1'b1, 32'h3008, OpLb, 32'h13, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    check("sb landed", mem[4], 32'hAB345678);
    check("lb load_pending", {31'h0, m_load_pending}, 32'h1);
    check("lb fwd_we", {31'h0, m_fwd_we}, 32'h0);

    issue(1'b1, 32'h300C, OpLbu, 32'h13, 32'h0, 32'h0, 5'd9, 1'b1);
    tick();
    check("lb grf_we", {31'h0, w_grf_we}, 32'h1);
    check("lb grf_addr", {27'h0, w_grf_addr}, 32'h8);
    check("lb grf_wdata", w_grf_wdata, 32'hFFFFFFAB);
    check("lb w_inst_addr", w_inst_addr, 32'h3008);

    issue(1'b1, 32'h3010, OpSh, 32'h22, 32'h00008001, 32'h0, 5'd0, 1'b0);
    tick();
    check("lbu grf_addr", {27'h0, w_grf_addr}, 32'h9);
    check("lbu grf_wdata", w_grf_wdata, 32'h000000AB);
    check("sh byteen", {28'h0, m_data_byteen}, 32'hC);
    check("sh wdata", m_data_wdata, 32'h80018001);

    issue(1'b1, 32'h3014, OpLh, 32'h22, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    check("sh landed", mem[8], 32'h80010000);

    issue(1'b1, 32'h3018, OpLhu, 32'h22, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    check("lh grf_we", {31'h0, w_grf_we}, 32'h1);
    check("lh grf_addr", {27'h0, w_grf_addr}, 32'h5);
    check("lh grf_wdata", w_grf_wdata, 32'hFFFF8001);

    issue(1'b1, 32'h3020, OpLw, 32'h5, 32'h0, 32'h0, 5'd3, 1'b1);
    tick();
    check("lhu grf_wdata", w_grf_wdata, 32'h00008001);
    check("lw mis misalign", {31'h0, m_misalign}, 32'h1);
    check("lw mis byteen", {28'h0, m_data_byteen}, 32'h0);

    issue(1'b1, 32'h3024, OpNone, 32'h0, 32'h0, 32'h55, 5'd0, 1'b1);
    tick();
    check("lw mis grf_we", {31'h0, w_grf_we}, 32'h0);
    check("lw mis w_inst_addr", w_inst_addr, 32'h3020);
    check("rd0 fwd_we", {31'h0, m_fwd_we}, 32'h0);

    issue(1'b1, 32'h3028, OpNone, 32'h0, 32'h0, 32'h7, 5'd4, 1'b1);
    tick();
    check("rd0 grf_we", {31'h0, w_grf_we}, 32'h0);
    check("alu fwd_we", {31'h0, m_fwd_we}, 32'h1);
    check("alu fwd_rd", {27'h0, m_fwd_rd}, 32'h4);
    check("alu fwd_data", m_fwd_data, 32'h7);

    issue(1'b1, 32'h302C, OpLw, 32'h10, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    check("alu grf_we", {31'h0, w_grf_we}, 32'h1);
    check("alu grf_wdata", w_grf_wdata, 32'h7);
    check("lw load_pending", {31'h0, m_load_pending}, 32'h1);

    issue(1'b1, 32'h3030, OpSw, 32'h12, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0);
    tick();
    check("lw pending one cycle", {31'h0, m_load_pending}, 32'h0);
    check("lw grf_wdata", w_grf_wdata, 32'hAB345678);
    check("sw mis byteen", {28'h0, m_data_byteen}, 32'h0);
    check("sw mis misalign", {31'h0, m_misalign}, 32'h1);

    // Load heading to W and a store in M when reset hits mid-stream
    issue(1'b1, 32'h3034, OpLw, 32'h10, 32'h0, 32'h0, 5'd7, 1'b1);
    tick();
    check("sw mis mem4 intact", mem[4], 32'hAB345678);
    issue(1'b1, 32'h3038, OpSw, 32'h30, 32'h11111111, 32'h0, 5'd0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check_quiet("mid reset comb");
    tick();
    check_quiet("mid reset edge");
    reset = 1'b0;
    issue(1'b0, 32'h0, OpNone, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    check_quiet("after mid reset");
    check("mid reset mem12", mem[12], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
